// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the EX stage.
//               Radix-2 shift-add multiply and restoring divide, one step per
//               cycle, with a single-cycle fast path for divide-by-zero and
//               signed overflow. STALL holds the front of the pipeline until
//               the one-cycle DONE pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FLUSH,
  input  logic            START,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  output logic [XLEN-1:0] RESULT,
  output logic            DONE,
  output logic            STALL
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [2:0]        func3_q;
  logic [XLEN-1:0]   b_mag;
  logic              neg_res;   // product sign, or quotient sign for divides
  logic              neg_rem;   // remainder follows the sign of the dividend
  logic [2*XLEN-1:0] acc;       // mul: {partial high, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]     counter;

  // Operand decode while IDLE: signedness, magnitudes and special cases
  logic            in_is_div;
  logic            in_a_signed;
  logic            in_b_signed;
  logic            in_sign_a;
  logic            in_sign_b;
  logic [XLEN-1:0] in_mag_a;
  logic [XLEN-1:0] in_mag_b;
  logic            in_div_zero;
  logic            in_overflow;
  logic            in_fast;
  logic [XLEN-1:0] in_fast_result;

  // Decode the incoming op and compute the fast-path result
  always_comb begin
    in_is_div   = FUNC3[2];
    in_a_signed = (FUNC3 == 3'b001) || (FUNC3 == 3'b010) ||
                  (FUNC3 == 3'b100) || (FUNC3 == 3'b110);
    in_b_signed = (FUNC3 == 3'b001) || (FUNC3 == 3'b100) || (FUNC3 == 3'b110);
    in_sign_a   = in_a_signed & OPERAND_A[XLEN-1];
    in_sign_b   = in_b_signed & OPERAND_B[XLEN-1];
    in_mag_a    = in_sign_a ? -OPERAND_A : OPERAND_A;
    in_mag_b    = in_sign_b ? -OPERAND_B : OPERAND_B;
    in_div_zero = in_is_div & (OPERAND_B == '0);
    in_overflow = in_is_div & ~FUNC3[0] &
                  (OPERAND_A == {1'b1, {(XLEN-1){1'b0}}}) & (OPERAND_B == '1);
    in_fast     = in_div_zero | in_overflow;
    if (in_div_zero) begin
      in_fast_result = FUNC3[1] ? OPERAND_A : '1;
    end else begin
      // Overflow: quotient is the most negative value, remainder is zero
      in_fast_result = FUNC3[1] ? '0 : OPERAND_A;
    end
  end

  // One radix-2 step of the multiplier and of the restoring divider
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_rem_sh;
  logic [XLEN:0]     div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_next;

  // Shift-add / shift-subtract step candidates
  always_comb begin
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b_mag : {XLEN{1'b0}})};
    mul_next   = {mul_sum, acc[XLEN-1:1]};
    div_rem_sh = acc[2*XLEN-1:XLEN-1];
    div_diff   = div_rem_sh - {1'b0, b_mag};
    div_ok     = ~div_diff[XLEN];
    div_next   = {(div_ok ? div_diff[XLEN-1:0] : div_rem_sh[XLEN-1:0]),
                  acc[XLEN-2:0], div_ok};
  end

  // Sign correction and word selection for the FINAL cycle
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   final_result;

  // Build the architectural result from the finished accumulator
  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (func3_q[2]) begin
      final_result = func3_q[1] ? rem : quo;
    end else if (func3_q == 3'b000) begin
      final_result = prod[XLEN-1:0];
    end else begin
      final_result = prod[2*XLEN-1:XLEN];
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, STALL and DONE decode
  always_comb begin
    state_next = state;
    STALL      = 1'b0;
    DONE       = 1'b0;
    case (state)
      S_IDLE: begin
        if (START && !FLUSH) begin
          STALL      = 1'b1;
          state_next = in_fast ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        STALL = 1'b1;
        if (counter == CW'(1)) begin
          state_next = S_FINAL;
        end
      end
      S_FINAL: begin
        STALL      = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        // START still reflects the instruction just completed
        DONE       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (FLUSH) begin
      state_next = S_IDLE;
    end
  end

  // Datapath: operand latch, iteration, and result register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      func3_q <= '0;
      b_mag   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      counter <= '0;
      RESULT  <= '0;
    end else if (!FLUSH) begin
      case (state)
        S_IDLE: begin
          if (START) begin
            func3_q <= FUNC3;
            b_mag   <= in_mag_b;
            neg_res <= in_sign_a ^ in_sign_b;
            neg_rem <= in_sign_a;
            acc     <= {{XLEN{1'b0}}, in_mag_a};
            counter <= CW'(XLEN);
            if (in_fast) begin
              RESULT <= in_fast_result;
            end
          end
        end
        S_RUN: begin
          acc     <= func3_q[2] ? div_next : mul_next;
          counter <= counter - CW'(1);
        end
        S_FINAL: begin
          RESULT <= final_result;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
